// File: rtl/demux_lane_ctrl.sv
// 1:2 L2 demux flow-control scheduler: round-robin lane steering gated by FIFO occupancy, plus link FSM.
// Optional per-lane word counters are enabled with `define DEMUX_CNT_EN.
module demux_lane_ctrl #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int UMB_W      = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [UMB_W-1:0]  umbral_AF_in,
  input  logic [UMB_W-1:0]  umbral_AE_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  fifo0_count,
  input  logic [CNT_W-1:0]  fifo1_count,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              sel,
  output logic              pause,
  output logic [4:0]        state,
  output logic              idle_out,
`ifdef DEMUX_CNT_EN
  output logic              error_out,
  output logic [7:0]        word_cnt0,
  output logic [7:0]        word_cnt1
`else
  output logic              error_out
`endif
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam int CMP_W = ((CNT_W > UMB_W) ? CNT_W : UMB_W) + 1;

  state_t              state_q, state_d;
  logic [UMB_W-1:0]    umb_af_q, umb_af_d;
  logic [UMB_W-1:0]    umb_ae_q, umb_ae_d;
  logic                rr_q, rr_d;
  logic                vo0_q, vo0_d;
  logic                vo1_q, vo1_d;
  logic [DATA_W-1:0]   do0_q, do0_d;
  logic [DATA_W-1:0]   do1_q, do1_d;
  logic                sel_q, sel_d;

  logic [CMP_W-1:0]    cnt0_w, cnt1_w, af_w, ae_w, depth_w, rr_cnt;
  logic                af0, af1, rr_af, alt_af, ae_ok;
  logic                route, lane;

  // Common-width operands so occupancy/threshold compares never truncate.
  always_comb begin
    cnt0_w  = CMP_W'(fifo0_count);
    cnt1_w  = CMP_W'(fifo1_count);
    af_w    = CMP_W'(umb_af_q);
    ae_w    = CMP_W'(umb_ae_q);
    depth_w = CMP_W'(FIFO_DEPTH);
    af0     = (cnt0_w >= af_w);
    af1     = (cnt1_w >= af_w);
    ae_ok   = (cnt0_w <= ae_w) && (cnt1_w <= ae_w);
    rr_af   = rr_q ? af1 : af0;
    alt_af  = rr_q ? af0 : af1;
    rr_cnt  = rr_q ? cnt1_w : cnt0_w;
  end

  always_comb begin
    state_d  = state_q;
    umb_af_d = umb_af_q;
    umb_ae_d = umb_ae_q;
    rr_d     = rr_q;
    route    = 1'b0;
    lane     = rr_q;
    pause    = 1'b1;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (init) begin
          umb_af_d = umbral_AF_in;
          umb_ae_d = umbral_AE_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        pause = af0 & af1;
        if (init) begin
          state_d = ST_INIT;
        end else if (valid_in) begin
          state_d = ST_ACTIVE;
          // Both lanes almost-full still accept into rr until it would overflow.
          if (!rr_af) begin
            route = 1'b1;
            lane  = rr_q;
          end else if (!alt_af) begin
            route = 1'b1;
            lane  = ~rr_q;
          end else if (rr_cnt < depth_w) begin
            route = 1'b1;
            lane  = rr_q;
          end else begin
            state_d = ST_ERROR;
          end
        end else if ((state_q == ST_ACTIVE) && ae_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
    if (route) rr_d = ~lane;
  end

  always_comb begin
    vo0_d = route & ~lane;
    vo1_d = route & lane;
    do0_d = (route && !lane) ? data_in : do0_q;
    do1_d = (route && lane)  ? data_in : do1_q;
    sel_d = route ? lane : sel_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      umb_af_q <= '0;
      umb_ae_q <= '0;
      rr_q     <= 1'b0;
      vo0_q    <= 1'b0;
      vo1_q    <= 1'b0;
      do0_q    <= '0;
      do1_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      umb_af_q <= umb_af_d;
      umb_ae_q <= umb_ae_d;
      rr_q     <= rr_d;
      vo0_q    <= vo0_d;
      vo1_q    <= vo1_d;
      do0_q    <= do0_d;
      do1_q    <= do1_d;
      sel_q    <= sel_d;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [7:0] wc0_q, wc0_d;
  logic [7:0] wc1_q, wc1_d;
  logic       init_entry;

  // Counters advance on the same edge that raises the matching strobe.
  always_comb begin
    init_entry = (state_d == ST_INIT) && (state_q != ST_INIT);
    wc0_d      = wc0_q;
    wc1_d      = wc1_q;
    if (init_entry) begin
      wc0_d = '0;
      wc1_d = '0;
    end else begin
      if (vo0_d) wc0_d = wc0_q + 8'd1;
      if (vo1_d) wc1_d = wc1_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wc0_q <= '0;
      wc1_q <= '0;
    end else begin
      wc0_q <= wc0_d;
      wc1_q <= wc1_d;
    end
  end

  assign word_cnt0 = wc0_q;
  assign word_cnt1 = wc1_q;
`endif

  assign valid_out0 = vo0_q;
  assign valid_out1 = vo1_q;
  assign data_out0  = do0_q;
  assign data_out1  = do1_q;
  assign sel        = sel_q;
  assign state      = state_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign error_out  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_demux_lane_ctrl.sv
// Directed bench for demux_lane_ctrl: link FSM, round-robin steering, gating, overflow and reset.
module tb_demux_lane_ctrl;

  logic       clk = 1'b0;
  logic       reset_L, init, valid_in, sel, pause, idle_out, error_out;
  logic [2:0] umbral_AF_in, umbral_AE_in;
  logic [7:0] data_in, data_out0, data_out1;
  logic [3:0] fifo0_count, fifo1_count;
  logic       valid_out0, valid_out1;
  logic [4:0] state;
`ifdef DEMUX_CNT_EN
  logic [7:0] word_cnt0, word_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;

  demux_lane_ctrl #(.DATA_W(8), .CNT_W(4), .FIFO_DEPTH(8), .UMB_W(3)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_AF_in (umbral_AF_in),
    .umbral_AE_in (umbral_AE_in),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .fifo0_count  (fifo0_count),
    .fifo1_count  (fifo1_count),
    .valid_out0   (valid_out0),
    .valid_out1   (valid_out1),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .sel          (sel),
    .pause        (pause),
    .state        (state),
    .idle_out     (idle_out),
`ifdef DEMUX_CNT_EN
    .error_out    (error_out),
    .word_cnt0    (word_cnt0),
    .word_cnt1    (word_cnt1)
`else
    .error_out    (error_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic e0, input logic e1);
    check({tag, "_vo0"}, {31'd0, valid_out0}, {31'd0, e0});
    check({tag, "_vo1"}, {31'd0, valid_out1}, {31'd0, e1});
  endtask

  initial begin
    reset_L = 1'b1; init = 1'b0; valid_in = 1'b0; data_in = '0;
    umbral_AF_in = '0; umbral_AE_in = '0; fifo0_count = '0; fifo1_count = '0;
    #2 reset_L = 1'b0;
    tick(); tick();
    check("rst_state", {27'd0, state}, {27'd0, S_RESET});
    strobes("rst", 1'b0, 1'b0);
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_do0", {24'd0, data_out0}, 32'd0);
    check("rst_idle", {31'd0, idle_out}, 32'd0);
    check("rst_err", {31'd0, error_out}, 32'd0);
    check("rst_pause", {31'd0, pause}, 32'd1);

    // Bring-up with AF=6 / AE=1
    reset_L = 1'b1; init = 1'b1; umbral_AF_in = 3'd6; umbral_AE_in = 3'd1;
    tick();
    check("init_state", {27'd0, state}, {27'd0, S_INIT});
    check("init_pause", {31'd0, pause}, 32'd1);
    tick();
    init = 1'b0;
    tick();
    check("idle_state", {27'd0, state}, {27'd0, S_IDLE});
    check("idle_out", {31'd0, idle_out}, 32'd1);
    strobes("idle", 1'b0, 1'b0);
    check("idle_pause", {31'd0, pause}, 32'd0);

    // Round-robin with empty lanes
    valid_in = 1'b1; data_in = 8'h10;
    tick();
    strobes("rr_w0", 1'b1, 1'b0);
    check("rr_w0_do0", {24'd0, data_out0}, 32'h10);
    check("rr_w0_sel", {31'd0, sel}, 32'd0);
    check("rr_active", {27'd0, state}, {27'd0, S_ACTIVE});
    data_in = 8'h12;
    tick();
    strobes("rr_w1", 1'b0, 1'b1);
    check("rr_w1_do1", {24'd0, data_out1}, 32'h12);
    check("rr_w1_sel", {31'd0, sel}, 32'd1);
    data_in = 8'h0A;
    tick();
    strobes("rr_w2", 1'b1, 1'b0);
    check("rr_w2_do0", {24'd0, data_out0}, 32'h0A);
    check("rr_w2_hold1", {24'd0, data_out1}, 32'h12);
    data_in = 8'h14;
    tick();
    strobes("rr_w3", 0, 1);
    check("rr_w3_do1", {24'd0, data_out1}, 32'h14);

    // Lane 0 almost-full: everything steers to lane 1
    fifo0_count = 4'd6; fifo1_count = 4'd2; data_in = 8'h21;
    #1 check("gate_pause", {31'd0, pause}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      strobes("gate", 1'b0, 1'b1);
      check("gate_do1", {24'd0, data_out1}, 32'h21 + 32'(i));
      data_in = 8'h22 + 8'(i);
    end

    // Both almost-full but below depth: rr (lane 0) still accepts
    fifo0_count = 4'd6; fifo1_count = 4'd6; data_in = 8'hAA;
    #1 check("both_af_pause", {31'd0, pause}, 32'd1);
    tick();
    strobes("both_af", 1'b1, 1'b0);
    check("both_af_do0", {24'd0, data_out0}, 32'hAA);
    check("both_af_state", {27'd0, state}, {27'd0, S_ACTIVE});

    // No word, counts above AE: stay ACTIVE, outputs hold
    valid_in = 1'b0;
    tick();
    strobes("hold", 1'b0, 1'b0);
    check("hold_state", {27'd0, state}, {27'd0, S_ACTIVE});
    check("hold_do0", {24'd0, data_out0}, 32'hAA);
    fifo0_count = 4'd1; fifo1_count = 4'd0;
    tick();
    check("drain_idle", {27'd0, state}, {27'd0, S_IDLE});

    // init together with valid in IDLE: INIT wins, word dropped
    fifo0_count = '0; fifo1_count = '0;
    init = 1'b1; valid_in = 1'b1; data_in = 8'h55;
    tick();
    check("initwin_state", {27'd0, state}, {27'd0, S_INIT});
    strobes("initwin", 1'b0, 1'b0);
    tick();
    check("init_ign_valid", {31'd0, valid_out0 | valid_out1}, 32'd0);
    init = 1'b0; valid_in = 1'b0;
    tick();
    check("reidle_state", {27'd0, state}, {27'd0, S_IDLE});

    // rr survived INIT: next word goes to lane 1
    valid_in = 1'b1; data_in = 8'h66;
    tick();
    strobes("rr_keep", 1'b0, 1'b1);
    check("rr_keep_do1", {24'd0, data_out1}, 32'h66);
    data_in = 8'h77;
    tick();
    strobes("pre_rst", 1'b1, 1'b0);

    // Async reset mid-cycle clears pending strobe immediately
    #2 reset_L = 1'b0;
    #1;
    check("async_vo0", {31'd0, valid_out0}, 32'd0);
    check("async_state", {27'd0, state}, {27'd0, S_RESET});
    check("async_do0", {24'd0, data_out0}, 32'd0);
    check("async_sel", {31'd0, sel}, 32'd0);

    // Re-init with AF=0: both lanes permanently almost-full
    reset_L = 1'b1; init = 1'b1; valid_in = 1'b0;
    umbral_AF_in = 3'd0; umbral_AE_in = 3'd0;
    tick();
    tick();
    init = 1'b0;
    tick();
    check("af0_idle", {27'd0, state}, {27'd0, S_IDLE});
    fifo0_count = 4'd3; fifo1_count = 4'd5; valid_in = 1'b1; data_in = 8'h88;
    #1 check("af0_pause", {31'd0, pause}, 32'd1);
    tick();
    strobes("af0_w0", 1'b1, 1'b0);
    check("af0_w0_do0", {24'd0, data_out0}, 32'h88);
    data_in = 8'h99;
    tick();
    strobes("af0_w1", 1'b0, 1'b1);
    check("af0_w1_do1", {24'd0, data_out1}, 32'h99);

    // Overflow: rr lane at depth -> drop and ERROR
    fifo0_count = 4'd8; fifo1_count = 4'd8; data_in = 8'hBB;
    tick();
    strobes("ovf", 1'b0, 1'b0);
    check("ovf_state", {27'd0, state}, {27'd0, S_ERROR});
    check("ovf_err", {31'd0, error_out}, 32'd1);
    check("ovf_pause", {31'd0, pause}, 32'd1);
    check("ovf_do0", {24'd0, data_out0}, 32'h88);

    // ERROR is sticky against init and traffic
    fifo0_count = '0; fifo1_count = '0; init = 1'b1; data_in = 8'hCC;
    tick();
    check("err_sticky", {27'd0, state}, {27'd0, S_ERROR});
    strobes("err", 1'b0, 1'b0);
    init = 1'b0; valid_in = 1'b0;
    reset_L = 1'b0;
    #1;
    check("err_clr_state", {27'd0, state}, {27'd0, S_RESET});
    check("err_clr_flag", {31'd0, error_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
